// File: rtl/sprite_blitter_pkg.sv
// rtl/sprite_blitter_pkg.sv - shared frame buffer geometry, key color and blitter state encoding
package sprite_blitter_pkg;

    localparam int          FB_WIDTH  = 160;
    localparam int          FB_HEIGHT = 120;
    localparam int          FB_ADDR_W = 15;
    localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

    typedef enum logic [1:0] {
        BLT_IDLE = 2'd0,
        BLT_RUN  = 2'd1,
        BLT_DONE = 2'd2
    } blt_state_t;

endpackage

// File: rtl/sprite_blitter_fb_addr_calc.sv
// rtl/sprite_blitter_fb_addr_calc.sv - combinational screen position, clip test and frame buffer address
module fb_addr_calc
    import sprite_blitter_pkg::*;
#(
    parameter int FB_WIDTH  = sprite_blitter_pkg::FB_WIDTH,
    parameter int FB_HEIGHT = sprite_blitter_pkg::FB_HEIGHT,
    parameter int FB_ADDR_W = sprite_blitter_pkg::FB_ADDR_W
) (
    input  logic [7:0]           ox,
    input  logic [6:0]           oy,
    input  logic [7:0]           col,
    input  logic [6:0]           row,
    output logic [8:0]           x,
    output logic [7:0]           y,
    output logic                 in_bounds,
    output logic [FB_ADDR_W-1:0] addr
);

    localparam logic [31:0] WIDTH_BITS = 32'(FB_WIDTH);

    // Widened sums so a sprite hanging off the right/bottom edge never wraps back on screen
    assign x = {1'b0, ox} + {1'b0, col};
    assign y = {1'b0, oy} + {1'b0, row};

    assign in_bounds = (32'(x) < 32'(FB_WIDTH)) && (32'(y) < 32'(FB_HEIGHT));

    // y*FB_WIDTH + x as a sum of shifted copies of y, one per set bit of the width constant
    always_comb begin
        addr = FB_ADDR_W'(x);
        for (int i = 0; i < 32; i++) begin
            if (WIDTH_BITS[i]) begin
                addr = addr + (FB_ADDR_W'(y) << i);
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - places a streamed sprite into the frame buffer with clipping and color key
module sprite_blitter
    import sprite_blitter_pkg::*;
#(
    parameter int          FB_WIDTH  = sprite_blitter_pkg::FB_WIDTH,
    parameter int          FB_HEIGHT = sprite_blitter_pkg::FB_HEIGHT,
    parameter int          FB_ADDR_W = sprite_blitter_pkg::FB_ADDR_W,
    parameter logic [23:0] KEY_COLOR = sprite_blitter_pkg::KEY_COLOR
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic [7:0]           ORIGIN_X,
    input  logic [6:0]           ORIGIN_Y,
    input  logic [7:0]           SPR_W,
    input  logic [6:0]           SPR_H,
    input  logic                 PIX_VALID,
    input  logic [23:0]          PIX_DATA,
    output logic                 FB_WE,
    output logic [FB_ADDR_W-1:0] FB_ADDR,
    output logic [23:0]          FB_DATA,
    output logic                 BUSY,
    output logic                 DONE
);

    blt_state_t state;
    blt_state_t state_next;

    logic [7:0]           ox_q;
    logic [6:0]           oy_q;
    logic [7:0]           w_q;
    logic [6:0]           h_q;
    logic [7:0]           col;
    logic [6:0]           row;

    logic [8:0]           pix_x;
    logic [7:0]           pix_y;
    logic                 in_bounds;
    logic [FB_ADDR_W-1:0] pix_addr;

    logic                 col_last;
    logic                 last_pix;
    logic                 write_ok;
    logic                 accept_start;
    logic                 accept_pix;
    logic                 unused_xy;

    fb_addr_calc #(
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .FB_ADDR_W (FB_ADDR_W)
    ) u_addr (
        .ox        (ox_q),
        .oy        (oy_q),
        .col       (col),
        .row       (row),
        .x         (pix_x),
        .y         (pix_y),
        .in_bounds (in_bounds),
        .addr      (pix_addr)
    );

    // Position is consumed only through the clip flag and address
    assign unused_xy = ^{pix_x, pix_y};

    assign accept_start = (state == BLT_IDLE) && START;
    assign accept_pix   = (state == BLT_RUN) && PIX_VALID;
    assign col_last     = (col == w_q - 8'd1);
    assign last_pix     = col_last && (row == h_q - 7'd1);
    assign write_ok     = in_bounds && (PIX_DATA != KEY_COLOR);

    assign BUSY = (state == BLT_RUN);
    assign DONE = (state == BLT_DONE);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= BLT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: empty sprites finish immediately, otherwise the last accepted pixel ends RUN
    always_comb begin
        state_next = state;
        case (state)
            BLT_IDLE: begin
                if (START) begin
                    state_next = ((SPR_W == 8'd0) || (SPR_H == 7'd0)) ? BLT_DONE : BLT_RUN;
                end
            end
            BLT_RUN: begin
                if (PIX_VALID && last_pix) begin
                    state_next = BLT_DONE;
                end
            end
            BLT_DONE: state_next = BLT_IDLE;
            default:  state_next = BLT_IDLE;
        endcase
    end

    // Sprite parameters, raster counters and the registered write port
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ox_q    <= '0;
            oy_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col     <= '0;
            row     <= '0;
            FB_WE   <= 1'b0;
            FB_ADDR <= '0;
            FB_DATA <= '0;
        end else begin
            FB_WE <= 1'b0;
            if (accept_start) begin
                ox_q <= ORIGIN_X;
                oy_q <= ORIGIN_Y;
                w_q  <= SPR_W;
                h_q  <= SPR_H;
                col  <= '0;
                row  <= '0;
            end
            if (accept_pix) begin
                FB_WE <= write_ok;
                if (write_ok) begin
                    FB_ADDR <= pix_addr;
                    FB_DATA <= PIX_DATA;
                end
                if (col_last) begin
                    col <= '0;
                    row <= row + 7'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - directed scoreboard bench for sprite_blitter
module tb_sprite_blitter;
    import sprite_blitter_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  ORIGIN_X;
    logic [6:0]  ORIGIN_Y;
    logic [7:0]  SPR_W;
    logic [6:0]  SPR_H;
    logic        PIX_VALID;
    logic [23:0] PIX_DATA;
    logic        FB_WE;
    logic [14:0] FB_ADDR;
    logic [23:0] FB_DATA;
    logic        BUSY;
    logic        DONE;

    sprite_blitter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .START     (START),
        .ORIGIN_X  (ORIGIN_X),
        .ORIGIN_Y  (ORIGIN_Y),
        .SPR_W     (SPR_W),
        .SPR_H     (SPR_H),
        .PIX_VALID (PIX_VALID),
        .PIX_DATA  (PIX_DATA),
        .FB_WE     (FB_WE),
        .FB_ADDR   (FB_ADDR),
        .FB_DATA   (FB_DATA),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          addr;
        logic [23:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    int  done_count = 0;
    int  m_ox, m_oy, m_w, m_h, m_col, m_row;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write, in the expected cycle
    always @(negedge CLK) begin
        if (DONE === 1'b1) done_count++;
        if (FB_WE !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(FB_WE), 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(FB_ADDR), 64'(e.addr));
                chk("wr_data", 64'(FB_DATA), 64'(e.data));
                chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_sprite(input int ox, input int oy, input int w, input int h, input logic with_pix);
        ORIGIN_X  = 8'(ox);
        ORIGIN_Y  = 7'(oy);
        SPR_W     = 8'(w);
        SPR_H     = 7'(h);
        START     = 1'b1;
        PIX_VALID = with_pix;
        PIX_DATA  = 24'h0000AA;
        step();
        START     = 1'b0;
        PIX_VALID = 1'b0;
        m_ox = ox; m_oy = oy; m_w = w; m_h = h; m_col = 0; m_row = 0;
    endtask

    task automatic send_pix(input logic [23:0] d);
        int x, y;
        wr_t e;
        x = m_ox + m_col;
        y = m_oy + m_row;
        if (x < 160 && y < 120 && d != KEY_COLOR) begin
            e.addr = y * 160 + x;
            e.data = d;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        if (m_col == m_w - 1) begin
            m_col = 0;
            m_row++;
        end else begin
            m_col++;
        end
        PIX_VALID = 1'b1;
        PIX_DATA  = d;
        step();
        PIX_VALID = 1'b0;
    endtask

    task automatic finish_chk(input string tag, input int dc_before);
        #5;
        chk({tag, "_done"}, 64'(DONE), 64'd1);
        chk({tag, "_busy_low"}, 64'(BUSY), 64'd0);
        chk({tag, "_all_writes"}, 64'(exp_q.size()), 64'd0);
        step();
        chk({tag, "_done_pulse"}, 64'(DONE), 64'd0);
        chk({tag, "_done_count"}, 64'(done_count), 64'(dc_before + 1));
    endtask

    initial begin
        int dc;
        logic [23:0] d;

        RESET = 1'b1; START = 1'b0; PIX_VALID = 1'b0; PIX_DATA = '0;
        ORIGIN_X = '0; ORIGIN_Y = '0; SPR_W = '0; SPR_H = '0;
        repeat (3) step();
        chk("rst_we", 64'(FB_WE), 64'd0);
        chk("rst_addr", 64'(FB_ADDR), 64'd0);
        chk("rst_data", 64'(FB_DATA), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        RESET = 1'b0;
        step();

        // 2x2 at (10,5); a pixel alongside START must be ignored
        dc = done_count;
        start_sprite(10, 5, 2, 2, 1'b1);
        chk("t1_busy", 64'(BUSY), 64'd1);
        send_pix(24'h102030);
        send_pix(24'h405060);
        send_pix(24'h708090);
        send_pix(24'hA0B0C0);
        finish_chk("t1", dc);

        // 3x1 at (0,0) with a keyed middle pixel
        dc = done_count;
        start_sprite(0, 0, 3, 1, 1'b0);
        send_pix(24'h112233);
        send_pix(KEY_COLOR);
        send_pix(24'h445566);
        finish_chk("t2", dc);

        // 4x2 at the bottom-right corner, mostly clipped
        dc = done_count;
        start_sprite(158, 119, 4, 2, 1'b0);
        for (int i = 0; i < 8; i++) send_pix(24'h010101 * (i + 1));
        finish_chk("t3", dc);

        // Zero-size sprites finish at once with no writes
        dc = done_count;
        start_sprite(5, 5, 0, 3, 1'b0);
        #5;
        chk("w0_done", 64'(DONE), 64'd1);
        chk("w0_busy", 64'(BUSY), 64'd0);
        step();
        chk("w0_done_pulse", 64'(DONE), 64'd0);
        start_sprite(5, 5, 3, 0, 1'b0);
        #5;
        chk("h0_done", 64'(DONE), 64'd1);
        step();
        chk("h0_count", 64'(done_count), 64'(dc + 2));

        // START while busy must not disturb the latched origin
        dc = done_count;
        start_sprite(10, 5, 2, 2, 1'b0);
        send_pix(24'h0A0B0C);
        ORIGIN_X = 8'd50; ORIGIN_Y = 7'd50; SPR_W = 8'd1; SPR_H = 7'd1;
        START = 1'b1;
        step();
        START = 1'b0;
        chk("busy_start_ignored", 64'(BUSY), 64'd1);
        send_pix(24'h0D0E0F);
        send_pix(24'h101112);
        send_pix(24'h131415);
        finish_chk("t5", dc);

        // Random idle gaps between pixels
        dc = done_count;
        start_sprite(20, 30, 5, 3, 1'b0);
        for (int i = 0; i < 15; i++) begin
            d = 24'($urandom);
            if (d == KEY_COLOR) d = d ^ 24'h1;
            send_pix(d);
            if (i != 14) repeat ($urandom_range(0, 3)) step();
        end
        finish_chk("t6", dc);

        // Reset arrives with pixel 3 of a 4x4 sprite
        start_sprite(0, 0, 4, 4, 1'b0);
        send_pix(24'h212223);
        send_pix(24'h242526);
        RESET = 1'b1;
        PIX_VALID = 1'b1;
        PIX_DATA = 24'h272829;
        step();
        PIX_VALID = 1'b0;
        chk("mid_rst_we", 64'(FB_WE), 64'd0);
        chk("mid_rst_addr", 64'(FB_ADDR), 64'd0);
        chk("mid_rst_data", 64'(FB_DATA), 64'd0);
        chk("mid_rst_busy", 64'(BUSY), 64'd0);
        chk("mid_rst_done", 64'(DONE), 64'd0);
        RESET = 1'b0;
        dc = done_count;
        repeat (4) step();
        chk("mid_rst_no_done", 64'(done_count), 64'(dc));
        chk("mid_rst_no_writes", 64'(exp_q.size()), 64'd0);
        start_sprite(1, 1, 1, 1, 1'b0);
        send_pix(24'h2A2B2C);
        finish_chk("t7", dc);

        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
